// File: rtl/cpu_mem_pkg.sv
// Shared types and helpers for the CPU data-side RAM port arbiter.
// Used by ram_port_arbiter and rr_arbiter.
package cpu_mem_pkg;

  localparam int MAX_RAM_LAT = 4;
  localparam int MAX_REQ     = 8;
  localparam int MAX_ADDR_W  = 32;
  localparam int MAX_DATA_W  = 32;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } arb_state_e;

  // Sized for the widest supported configuration; users slice down.
  typedef struct packed {
    logic                  write;
    logic [MAX_ADDR_W-1:0] addr;
    logic [MAX_DATA_W-1:0] wdata;
    logic [2:0]            owner;
  } mem_op_t;

  // First valid requester searching upward from ptr+1, wrapping at n.
  function automatic logic [MAX_REQ-1:0] rr_pick(input logic [MAX_REQ-1:0] valid,
                                                 input logic [2:0]         ptr,
                                                 input int unsigned        n);
    logic [MAX_REQ-1:0] pick;
    logic [2:0]         idx;
    logic               found;
    pick  = '0;
    found = 1'b0;
    for (int unsigned k = 1; k <= MAX_REQ; k++) begin
      idx = 3'((32'(ptr) + k) % n);
      if (k <= n && !found && valid[idx]) begin
        pick[idx] = 1'b1;
        found     = 1'b1;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/ram_port_arbiter_rr.sv
// Round-robin arbiter: combinational one-hot pick plus registered last-winner pointer.
// Generic enough to be reused for the bus/peripheral arbiter.
module rr_arbiter
  import cpu_mem_pkg::*;
#(
  parameter int NUM_REQ = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] valid,
  input  logic               enable,
  output logic [NUM_REQ-1:0] grant,
  output logic [2:0]         grant_idx
);

  logic [2:0]         ptr;
  logic [MAX_REQ-1:0] pick_full;
  logic               unused_pick;

  assign pick_full   = rr_pick(MAX_REQ'(valid), ptr, NUM_REQ);
  assign grant       = enable ? pick_full[NUM_REQ-1:0] : '0;
  assign unused_pick = ^pick_full;

  always_comb begin
    grant_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) grant_idx = 3'(i);
    end
  end

  // Pointer starts at the last requester so requester 0 wins first after reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr <= 3'(NUM_REQ - 1);
    end else if (|grant) begin
      ptr <= grant_idx;
    end
  end

endmodule

// File: rtl/ram_port_arbiter.sv
// Shares one RAM port between NUM_REQ requesters, one transaction at a time, fixed read latency.
// Optional macro RAM_ARB_PERF_EN adds saturating per-requester grant and stall counters.
module ram_port_arbiter
  import cpu_mem_pkg::*;
#(
  parameter int NUM_REQ = 3,
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 8,
  parameter int RAM_LAT = 1
) (
  input  logic                      clka,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ-1:0]        req_write,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]         rsp_rdata,
  output logic                      ram_en,
  output logic                      ram_we,
  output logic [ADDR_W-1:0]         ram_addr,
  output logic [DATA_W-1:0]         ram_wdata,
  input  logic [DATA_W-1:0]         ram_rdata
`ifdef RAM_ARB_PERF_EN
  ,
  output logic [NUM_REQ*16-1:0]     perf_grants,
  output logic [15:0]               perf_stall
`endif
);

  localparam int CNT_W = $clog2(MAX_RAM_LAT);

  if (NUM_REQ < 2 || NUM_REQ > MAX_REQ || RAM_LAT < 1 || RAM_LAT > MAX_RAM_LAT ||
      ADDR_W > MAX_ADDR_W || DATA_W > MAX_DATA_W) begin : g_param_check
    $error("ram_port_arbiter: NUM_REQ, RAM_LAT, ADDR_W or DATA_W out of range");
  end

  arb_state_e         state, state_nxt;
  mem_op_t            op;
  logic [CNT_W-1:0]   cnt;
  logic [NUM_REQ-1:0] grant;
  logic [2:0]         grant_idx;
  logic               can_grant;
  logic               handshake;
  logic [ADDR_W-1:0]  sel_addr;
  logic [DATA_W-1:0]  sel_wdata;
  logic               unused_op;

  // Ready is forced low while reset is held, not just after the state register clears.
  assign can_grant = rst && (state == IDLE || state == RESP);
  assign handshake = |grant;
  assign req_ready = grant;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .clk       (clka),
    .rst       (rst),
    .valid     (req_valid),
    .enable    (can_grant),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  always_comb begin
    sel_addr  = '0;
    sel_wdata = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        sel_addr  = req_addr[i*ADDR_W +: ADDR_W];
        sel_wdata = req_wdata[i*DATA_W +: DATA_W];
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (handshake) state_nxt = ISSUE;
      ISSUE:   state_nxt = (RAM_LAT == 1) ? RESP : WAIT;
      WAIT:    if (cnt == CNT_W'(1)) state_nxt = RESP;
      RESP:    state_nxt = handshake ? ISSUE : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // cnt holds the number of WAIT cycles still to run, loaded while in ISSUE.
  always_ff @(posedge clka or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      cnt   <= '0;
      op    <= '0;
    end else begin
      state <= state_nxt;
      if (state == ISSUE) begin
        cnt <= CNT_W'(RAM_LAT - 1);
      end else if (state == WAIT) begin
        cnt <= cnt - CNT_W'(1);
      end
      if (handshake) begin
        op.write <= |(req_write & grant);
        op.addr  <= MAX_ADDR_W'(sel_addr);
        op.wdata <= MAX_DATA_W'(sel_wdata);
        op.owner <= grant_idx;
      end
    end
  end

  assign ram_en    = (state == ISSUE);
  assign ram_we    = ram_en && op.write;
  assign ram_addr  = op.addr[ADDR_W-1:0];
  assign ram_wdata = op.wdata[DATA_W-1:0];
  assign unused_op = ^{op.addr, op.wdata};

  always_comb begin
    rsp_valid = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      rsp_valid[i] = (state == RESP) && (op.owner == 3'(i));
    end
  end

  // Writes complete with a zero data acknowledge; reads pass RAM data straight through.
  assign rsp_rdata = (state == RESP && !op.write) ? ram_rdata : '0;

`ifdef RAM_ARB_PERF_EN
  logic stall;
  assign stall = (|req_valid) && !handshake;

  always_ff @(posedge clka or negedge rst) begin
    if (!rst) begin
      perf_grants <= '0;
      perf_stall  <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (grant[i] && perf_grants[i*16 +: 16] != 16'hFFFF) begin
          perf_grants[i*16 +: 16] <= perf_grants[i*16 +: 16] + 16'd1;
        end
      end
      if (stall && perf_stall != 16'hFFFF) begin
        perf_stall <= perf_stall + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Bench for ram_port_arbiter: RAM_LAT=1 instance checked every cycle against a transaction-level model,
// RAM_LAT=3 instance checked with directed expectations. Define RAM_ARB_PERF_EN to test the counters.
module tb_ram_port_arbiter;

  localparam int N  = 3;
  localparam int AW = 16;
  localparam int DW = 8;

  logic clka = 1'b0;
  always #5 clka = ~clka;

  logic rst;
  logic preload;

  logic [N-1:0]    rv1, rw1, ready1, rspv1;
  logic [N*AW-1:0] ra1;
  logic [N*DW-1:0] rd1;
  logic [DW-1:0]   rsprd1, wd1, rdata1;
  logic            en1, we1;
  logic [AW-1:0]   addr1;

  logic [N-1:0]    rv3, rw3, ready3, rspv3;
  logic [N*AW-1:0] ra3;
  logic [N*DW-1:0] rd3;
  logic [DW-1:0]   rsprd3, wd3, rdata3, p0_3, p1_3;
  logic            en3, we3;
  logic [AW-1:0]   addr3;

`ifdef RAM_ARB_PERF_EN
  logic [N*16-1:0] pg1, pg3;
  logic [15:0]     ps1, ps3;
`endif

  ram_port_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .RAM_LAT(1)) dut1 (
    .clka(clka), .rst(rst), .req_valid(rv1), .req_write(rw1), .req_addr(ra1), .req_wdata(rd1),
    .req_ready(ready1), .rsp_valid(rspv1), .rsp_rdata(rsprd1), .ram_en(en1), .ram_we(we1),
    .ram_addr(addr1), .ram_wdata(wd1), .ram_rdata(rdata1)
`ifdef RAM_ARB_PERF_EN
    , .perf_grants(pg1), .perf_stall(ps1)
`endif
  );

  ram_port_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .RAM_LAT(3)) dut3 (
    .clka(clka), .rst(rst), .req_valid(rv3), .req_write(rw3), .req_addr(ra3), .req_wdata(rd3),
    .req_ready(ready3), .rsp_valid(rspv3), .rsp_rdata(rsprd3), .ram_en(en3), .ram_we(we3),
    .ram_addr(addr3), .ram_wdata(wd3), .ram_rdata(rdata3)
`ifdef RAM_ARB_PERF_EN
    , .perf_grants(pg3), .perf_stall(ps3)
`endif
  );

  function automatic logic [7:0] dflt(input logic [7:0] a);
    return a ^ 8'hB5;
  endfunction

  // Synchronous RAMs, 256 words indexed by the low address byte.
  logic [7:0] mem1 [0:255];
  logic [7:0] mem3 [0:255];

  always @(posedge clka) begin
    if (preload) begin
      for (int i = 0; i < 256; i++) mem1[i] <= dflt(8'(i));
    end else if (en1) begin
      if (we1) mem1[addr1[7:0]] <= wd1;
      else     rdata1 <= mem1[addr1[7:0]];
    end
  end

  always @(posedge clka) begin
    if (preload) begin
      for (int i = 0; i < 256; i++) mem3[i] <= dflt(8'(i));
    end else if (en3) begin
      if (we3) mem3[addr3[7:0]] <= wd3;
      else     p0_3 <= mem3[addr3[7:0]];
    end
    p1_3   <= p0_3;
    rdata3 <= p1_3;
  end

  int n_checks = 0;
  int n_errs   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction-level model of dut1: age counts cycles since the handshake.
  bit         m_active;
  int         m_age, m_ptr, m_owner;
  bit         m_write;
  logic [15:0] m_addr;
  logic [7:0]  m_wdata;
  logic [7:0]  shadow [int];

  function automatic logic [7:0] sh_rd(input logic [15:0] a);
    return shadow.exists(int'(a)) ? shadow[int'(a)] : dflt(a[7:0]);
  endfunction

  task automatic model_step();
    logic [2:0] e_ready, e_rsp;
    logic [7:0] e_rdata;
    bit resp_now, issue_now;
    int win;
    if (!rst) begin
      m_active = 0; m_ptr = N - 1; m_addr = '0; m_wdata = '0;
      chk("rst_ready", 32'(ready1), 0);
      chk("rst_rspv",  32'(rspv1),  0);
      chk("rst_en",    32'(en1),    0);
      chk("rst_we",    32'(we1),    0);
      chk("rst_addr",  32'(addr1),  0);
      chk("rst_wdata", 32'(wd1),    0);
      chk("rst_rdata", 32'(rsprd1), 0);
    end else begin
      resp_now  = m_active && (m_age == 2);
      issue_now = m_active && (m_age == 1);
      e_rsp     = resp_now ? 3'(1 << m_owner) : 3'b000;
      e_rdata   = (resp_now && !m_write) ? sh_rd(m_addr) : 8'h00;
      win = -1;
      if (!m_active || resp_now) begin
        for (int k = 1; k <= N; k++) begin
          int idx = (m_ptr + k) % N;
          if (win < 0 && rv1[idx]) win = idx;
        end
      end
      e_ready = (win >= 0) ? 3'(1 << win) : 3'b000;
      chk("m_ready", 32'(ready1), 32'(e_ready));
      chk("m_rspv",  32'(rspv1),  32'(e_rsp));
      chk("m_rdata", 32'(rsprd1), 32'(e_rdata));
      chk("m_en",    32'(en1),    32'(issue_now));
      chk("m_we",    32'(we1),    32'(issue_now && m_write));
      chk("m_addr",  32'(addr1),  32'(m_addr));
      chk("m_wdata", 32'(wd1),    32'(m_wdata));
      if (resp_now) begin
        if (m_write) shadow[int'(m_addr)] = m_wdata;
        m_active = 0;
      end
      if (win >= 0) begin
        m_active = 1; m_age = 0; m_ptr = win; m_owner = win;
        m_write = rw1[win];
        m_addr  = ra1[win*AW +: AW];
        m_wdata = rd1[win*DW +: DW];
      end
      if (m_active) m_age++;
    end
  endtask

  bit settled = 0;

  task automatic settle();
    @(negedge clka);
    model_step();
    #1;
    settled = 1;
  endtask

  task automatic adv();
    if (!settled) begin
      @(negedge clka);
      model_step();
    end
    @(posedge clka);
    #1;
    settled = 0;
  endtask

  task automatic set1(input int i, input bit v, input bit w, input logic [15:0] a, input logic [7:0] d);
    rv1[i] = v; rw1[i] = w; ra1[i*AW +: AW] = a; rd1[i*DW +: DW] = d;
  endtask

  task automatic set3(input int i, input bit v, input bit w, input logic [15:0] a, input logic [7:0] d);
    rv3[i] = v; rw3[i] = w; ra3[i*AW +: AW] = a; rd3[i*DW +: DW] = d;
  endtask

  task automatic do_reset();
    adv(); rst = 1'b0;
    adv(); rst = 1'b1;
  endtask

  initial begin
    int en_cnt, rsp_at;
    rst = 1'b0; preload = 1'b1;
    rv1 = '0; rw1 = '0; ra1 = '0; rd1 = '0;
    rv3 = '0; rw3 = '0; ra3 = '0; rd3 = '0;
    settle();
    chk("rst3_ready", 32'(ready3), 0);
    chk("rst3_rspv",  32'(rspv3),  0);
    chk("rst3_en",    32'(en3),    0);
    adv(); preload = 1'b0;
    adv(); rst = 1'b1;

    // Single read of a preloaded word
    adv(); set1(0, 1, 0, 16'h0010, 8'h00);
    settle(); chk("t1_ready", 32'(ready1), 32'h1);
    adv(); set1(0, 0, 0, 16'h0000, 8'h00);
    settle(); chk("t1_en", 32'(en1), 1); chk("t1_addr", 32'(addr1), 32'h10);
    adv();
    settle(); chk("t1_rspv", 32'(rspv1), 32'h1); chk("t1_rdata", 32'(rsprd1), 32'hA5);

    // Write then read-back, re-requesting in the owner's own RESP cycle
    adv(); set1(1, 1, 1, 16'h0200, 8'h3C);
    settle(); chk("t2_wr_ready", 32'(ready1), 32'h2);
    adv(); set1(1, 0, 0, 16'h0000, 8'h00);
    settle(); chk("t2_we", 32'(we1), 1); chk("t2_wdata", 32'(wd1), 32'h3C);
    adv(); set1(1, 1, 0, 16'h0200, 8'h00);
    settle(); chk("t2_wr_rspv", 32'(rspv1), 32'h2); chk("t2_wr_rdata", 32'(rsprd1), 0);
    chk("t2_rd_ready", 32'(ready1), 32'h2);
    adv(); set1(1, 0, 0, 16'h0000, 8'h00);
    adv();
    settle(); chk("t2_rd_rspv", 32'(rspv1), 32'h2); chk("t2_rd_rdata", 32'(rsprd1), 32'h3C);

    // A request dropped before it is granted is cancelled
    adv(); set1(0, 1, 0, 16'h0030, 8'h00);
    settle(); chk("t3_ready", 32'(ready1), 32'h1);
    adv(); set1(0, 0, 0, 16'h0000, 8'h00); set1(2, 1, 0, 16'h0010, 8'h00);
    settle(); chk("t3_busy_ready", 32'(ready1), 0);
    adv(); set1(2, 0, 0, 16'h0000, 8'h00);
    settle(); chk("t3_rdata", 32'(rsprd1), 32'h85); chk("t3_cancel", 32'(ready1), 0);

    // Three requesters held valid: grants 0,1,2,... every second cycle
    do_reset();
    adv();
    set1(0, 1, 0, 16'h0010, 8'h00);
    set1(1, 1, 0, 16'h0200, 8'h00);
    set1(2, 1, 0, 16'h0030, 8'h00);
    for (int c = 0; c < 12; c++) begin
      settle();
      if (c % 2 == 0) chk("t4_grant", 32'(ready1), 32'(1 << ((c / 2) % 3)));
      else            chk("t4_gap",   32'(ready1), 0);
      if (c >= 2 && c % 2 == 0) chk("t4_rsp", 32'(rspv1), 32'(1 << (((c / 2) - 1) % 3)));
      adv();
    end
    rv1 = '0;
    adv();

    // RAM_LAT=3: response four cycles after the handshake, one enable cycle
    adv(); set3(0, 1, 0, 16'h0010, 8'h00);
    settle(); chk("t5_ready", 32'(ready3), 32'h1);
    en_cnt = 0; rsp_at = -1;
    for (int k = 1; k <= 6; k++) begin
      adv();
      if (k == 1) set3(0, 0, 0, 16'h0000, 8'h00);
      settle();
      en_cnt += int'(en3);
      if (rspv3 == 3'b001 && rsp_at < 0) begin
        rsp_at = k;
        chk("t5_rdata", 32'(rsprd3), 32'hA5);
      end
    end
    chk("t5_en_cycles", 32'(en_cnt), 1);
    chk("t5_rsp_at", 32'(rsp_at), 4);

    // Reset during WAIT aborts; pending req2 wins after release
    do_reset();
    adv(); set3(0, 1, 0, 16'h0010, 8'h00); set3(2, 1, 0, 16'h0030, 8'h00);
    settle(); chk("t6_ready", 32'(ready3), 32'h1);
    adv(); set3(0, 0, 0, 16'h0000, 8'h00);
    settle(); chk("t6_issue_en", 32'(en3), 1); chk("t6_busy", 32'(ready3), 0);
    adv();
    settle(); chk("t6_wait_en", 32'(en3), 0);
    adv(); rst = 1'b0;
    settle(); chk("t6_rst_en", 32'(en3), 0); chk("t6_rst_rspv", 32'(rspv3), 0);
    chk("t6_rst_ready", 32'(ready3), 0);
    adv();
    settle(); chk("t6_rst_rspv2", 32'(rspv3), 0);
    adv(); rst = 1'b1;
    settle(); chk("t6_req2_first", 32'(ready3), 32'h4); chk("t6_no_rsp", 32'(rspv3), 0);
    rsp_at = -1;
    for (int k = 1; k <= 5; k++) begin
      adv();
      if (k == 1) set3(2, 0, 0, 16'h0000, 8'h00);
      settle();
      if (rspv3 == 3'b100 && rsp_at < 0) begin
        rsp_at = k;
        chk("t6_rdata", 32'(rsprd3), 32'h85);
      end
    end
    chk("t6_rsp_at", 32'(rsp_at), 4);

`ifdef RAM_ARB_PERF_EN
    // Five grants to req1, three cancelled req0 cycles while busy
    do_reset();
    for (int j = 0; j < 5; j++) begin
      adv(); set1(1, 1, 0, 16'h0010, 8'h00);
      settle();
      adv(); set1(1, 0, 0, 16'h0000, 8'h00);
      if (j < 3) set1(0, 1, 0, 16'h0030, 8'h00);
      settle();
      adv(); set1(0, 0, 0, 16'h0000, 8'h00);
      settle();
    end
    adv();
    settle();
    chk("perf_grants1", 32'(pg1[31:16]), 5);
    chk("perf_grants0", 32'(pg1[15:0]), 0);
    chk("perf_stall", 32'(ps1), 3);
`endif

    adv();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
    $finish;
  end

endmodule

// File: doc/ram_port_arbiter.md
Name: ram_port_arbiter

Overview:
- Shares the CPU's single data-side RAM port between NUM_REQ requesters: instruction fetch, load/store unit and debug/loader.
- Round-robin grant, one outstanding transaction at a time, fixed RAM read latency.
- Sits between the cpu core requesters and the RAM primitive inside cpu; clocked on the RAM write clock domain.

Parameters:
- NUM_REQ, 3: number of requesters; valid range 2..8.
- ADDR_W, 16: RAM word address width.
- DATA_W, 8: RAM data width.
- RAM_LAT, 1: cycles from ram_en sampled to ram_rdata valid; must be 1..4.

Ports:
- clka  in  1: clock, rising edge.
- rst  in  1: asynchronous reset, active-low.
- req_valid  in  NUM_REQ: per-requester request.
- req_write  in  NUM_REQ: 1 = write, 0 = read.
- req_addr  in  NUM_REQ*ADDR_W: packed addresses; requester i at slice i.
- req_wdata  in  NUM_REQ*DATA_W: packed write data.
- req_ready  out  NUM_REQ: one-hot grant; handshake when valid & ready.
- rsp_valid  out  NUM_REQ: one-cycle completion pulse to the owner.
- rsp_rdata  out  DATA_W: read data; valid with rsp_valid on reads.
- ram_en  out  1: RAM enable.
- ram_we  out  1: RAM write enable.
- ram_addr  out  ADDR_W: RAM address.
- ram_wdata  out  DATA_W: RAM write data.
- ram_rdata  in  DATA_W: RAM read data.

Behaviour:
- Reset (rst=0, asynchronous): state IDLE; ram_en, ram_we, ram_addr, ram_wdata, rsp_valid and req_ready all 0; rr pointer = NUM_REQ-1, so requester 0 wins first.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- Grant rules:
  - A grant may occur only in IDLE or RESP.
  - The winner is the first valid requester searching from pointer+1 mod NUM_REQ.
  - req_ready is combinational and one-hot, for the winner only.
  - On handshake in cycle t: latch op/addr/wdata/owner; pointer = winner.
- Cycle timing:
  - t+1: ISSUE. ram_en=1; ram_we=op; ram_addr/ram_wdata are registered copies.
  - ISSUE then WAIT for RAM_LAT-1 cycles (down-counter), then RESP. With RAM_LAT=1, ISSUE goes directly to RESP.
  - RESP at t+1+RAM_LAT: rsp_valid[owner]=1.
  - Reads: rsp_rdata = ram_rdata (combinational pass-through).
  - Writes: rsp_rdata = 0 (write acknowledge only).
  - In all other cycles rsp_rdata = 0.
- ram_en/ram_we are 0 outside ISSUE; addr/wdata hold their last values.
- Back-to-back: a new grant in RESP goes directly to ISSUE. Sustained period is RAM_LAT+1 cycles per access.
- RESP with no valid requester returns to IDLE.
- Requester contract: hold valid/write/addr/wdata stable until ready. Dropping valid before grant is legal and silently cancels the request.
- Requester contract: a requester may re-request in its own RESP cycle; round-robin still applies.
- Simultaneous requests: exactly one grant; no requester starves; worst-case wait = (NUM_REQ-1)*(RAM_LAT+1) cycles.
- Reset mid-transaction: abort immediately. No rsp_valid is issued; the RAM write may or may not have occurred.
- Out-of-range RAM_LAT or NUM_REQ: elaboration-time error.

Optional Feature:
- Macro: RAM_ARB_PERF_EN.
- Defined:
  - Adds output perf_grants (NUM_REQ*16): per-requester grant counters, saturating at 16'hFFFF.
  - Adds output perf_stall (16): counts cycles with any req_valid high and no handshake, saturating.
  - All counters clear on reset.
- Undefined: no counters and no extra ports; behaviour is otherwise identical.

Decomposition:
- Package cpu_mem_pkg holds:
  - arb_state_e enum (IDLE/ISSUE/WAIT/RESP).
  - mem_op_t struct {write, addr, wdata, owner}.
  - Constant MAX_RAM_LAT=4.
  - Helper function rr_pick(valid, ptr) returning a one-hot vector.
- Sub-module rr_arbiter:
  - Combinational pick plus registered pointer.
  - Reused later for the bus/peripheral arbiter.

Test Plan:
- Single read: RAM preloaded addr 0x0010=0xA5; req0 read 0x0010 at t → ready0 at t, ram_en at t+1, rsp_valid[0] with rsp_rdata=0xA5 at t+2.
- Write then read-back: req1 writes 0x3C to 0x0200, then reads 0x0200 → write acknowledged with rsp_rdata=0; read returns 0x3C.
- Three simultaneous requesters held valid → grant order 0,1,2,0,1,…, one grant every 2 cycles; no gaps.
- RAM_LAT=3: single read → rsp_valid 4 cycles after handshake; ram_en high exactly 1 cycle.
- Reset asserted during WAIT → ram_en=0 and no rsp_valid. After release, pending req2 is granted first by req_valid order, with pointer reset to NUM_REQ-1.
- With RAM_ARB_PERF_EN: 5 grants to req1 plus 3 stalled cycles → perf_grants[1]=5, perf_stall=3.
